// File: rtl/comp_pkg.sv
// Shared definitions for the comp RV32I-subset core: opcodes, FSM states and
// memory-mapped I/O addresses.
package comp_pkg;

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;

    localparam logic [31:0] OutAddr  = 32'd1000;
    localparam logic [31:0] HaltAddr = 32'd1004;
    localparam logic [31:0] OutfAddr = 32'd1008;

    typedef enum logic [4:0] {
        StFetch  = 5'd0,
        StExec   = 5'd1,
        StLoad   = 5'd2,
        StHalted = 5'd3
    } state_e;

    function automatic logic [31:0] imm_i(input logic [31:0] ir);
        return {{20{ir[31]}}, ir[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] ir);
        return {{20{ir[31]}}, ir[31:25], ir[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] ir);
        return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] ir);
        return {ir[31:12], 12'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] ir);
        return {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/comp_alu.sv
// Combinational integer ALU shared by register-register and register-immediate ops.
module comp_alu
    import comp_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        alt,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result
);

    always_comb begin
        result = '0;
        case (funct3)
            3'b000:  result = alt ? (a - b) : (a + b);
            3'b001:  result = a << b[4:0];
            3'b010:  result = {31'b0, $signed(a) < $signed(b)};
            3'b011:  result = {31'b0, a < b};
            3'b100:  result = a ^ b;
            3'b101:  result = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            3'b110:  result = a | b;
            3'b111:  result = a & b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/comp.sv
// Multi-cycle RV32I-subset core with unified word memory, out-of-band loader
// and memory-mapped integer/float output and halt registers.
module comp
    import comp_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 256,
    parameter logic [31:0] OUT_ADDR  = OutAddr,
    parameter logic [31:0] HALT_ADDR = HaltAddr,
    parameter logic [31:0] OUTF_ADDR = OutfAddr
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        oob_wen,
    input  logic [31:0] oob_wr_addr,
    input  logic [31:0] oob_wr_data,
    output logic [31:0] pc,
    output logic [6:0]  op,
    output logic [4:0]  rd,
    output logic [6:0]  imm1,
    output logic [31:0] x1,
    output logic [4:0]  state,
    output logic [31:0] out,
    output logic        outen,
    output logic        outflen,
    output logic        halt
);

    localparam int unsigned AW = $clog2(MEM_WORDS);

    logic [31:0] mem [MEM_WORDS];
    logic [31:0] regs_q [32];

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] ld_q, ld_d;
    logic [31:0] out_q, out_d;
    logic        outen_q, outen_d;
    logic        outflen_q, outflen_d;
    logic        halt_q, halt_d;

    logic        wb_en;
    logic [31:0] wb_val;
    logic        mem_we;

    // Instruction field decode
    logic [6:0]  opcode;
    logic [4:0]  rd_idx, rs1_idx, rs2_idx;
    logic [2:0]  f3;
    logic [31:0] rs1_v, rs2_v;
    logic [31:0] ls_addr;
    logic        is_mmio;
    logic        br_taken;

    assign opcode  = ir_q[6:0];
    assign rd_idx  = ir_q[11:7];
    assign f3      = ir_q[14:12];
    assign rs1_idx = ir_q[19:15];
    assign rs2_idx = ir_q[24:20];
    assign rs1_v   = regs_q[rs1_idx];
    assign rs2_v   = regs_q[rs2_idx];
    assign ls_addr = rs1_v + ((opcode == OpStore) ? imm_s(ir_q) : imm_i(ir_q));
    assign is_mmio = (ls_addr == OUT_ADDR) || (ls_addr == HALT_ADDR) || (ls_addr == OUTF_ADDR);

    logic [31:0] alu_b, alu_res;
    logic        alu_alt;

    assign alu_b   = (opcode == OpReg) ? rs2_v : imm_i(ir_q);
    // Immediate ops only use bit 30 as a modifier for right shifts.
    assign alu_alt = (opcode == OpReg) ? ir_q[30] : ((f3 == 3'b101) && ir_q[30]);

    comp_alu u_alu (
        .funct3 (f3),
        .alt    (alu_alt),
        .a      (rs1_v),
        .b      (alu_b),
        .result (alu_res)
    );

    always_comb begin
        br_taken = 1'b0;
        case (f3)
            3'b000:  br_taken = (rs1_v == rs2_v);
            3'b001:  br_taken = (rs1_v != rs2_v);
            3'b100:  br_taken = ($signed(rs1_v) < $signed(rs2_v));
            3'b101:  br_taken = ($signed(rs1_v) >= $signed(rs2_v));
            3'b110:  br_taken = (rs1_v < rs2_v);
            3'b111:  br_taken = (rs1_v >= rs2_v);
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        ld_d      = ld_q;
        out_d     = out_q;
        outen_d   = 1'b0;
        outflen_d = 1'b0;
        halt_d    = halt_q;
        wb_en     = 1'b0;
        wb_val    = '0;
        mem_we    = 1'b0;

        case (state_q)
            StFetch: begin
                ir_d    = mem[pc_q[AW+1:2]];
                state_d = StExec;
            end
            StExec: begin
                state_d = StFetch;
                pc_d    = pc_q + 32'd4;
                case (opcode)
                    OpLui: begin
                        wb_en  = 1'b1;
                        wb_val = imm_u(ir_q);
                    end
                    OpAuipc: begin
                        wb_en  = 1'b1;
                        wb_val = pc_q + imm_u(ir_q);
                    end
                    OpJal: begin
                        wb_en  = 1'b1;
                        wb_val = pc_q + 32'd4;
                        pc_d   = pc_q + imm_j(ir_q);
                    end
                    OpJalr: begin
                        wb_en  = 1'b1;
                        wb_val = pc_q + 32'd4;
                        pc_d   = (rs1_v + imm_i(ir_q)) & ~32'd1;
                    end
                    OpBranch: begin
                        if (br_taken) pc_d = pc_q + imm_b(ir_q);
                    end
                    OpLoad: begin
                        ld_d    = is_mmio ? 32'd0 : mem[ls_addr[AW+1:2]];
                        state_d = StLoad;
                    end
                    OpStore: begin
                        if (ls_addr == HALT_ADDR) begin
                            halt_d  = 1'b1;
                            state_d = StHalted;
                            pc_d    = pc_q;
                        end else if (ls_addr == OUT_ADDR) begin
                            out_d   = rs2_v;
                            outen_d = 1'b1;
                        end else if (ls_addr == OUTF_ADDR) begin
                            out_d     = rs2_v;
                            outflen_d = 1'b1;
                        end else begin
                            mem_we = 1'b1;
                        end
                    end
                    OpImm, OpReg: begin
                        wb_en  = 1'b1;
                        wb_val = alu_res;
                    end
                    default: begin
                        halt_d  = 1'b1;
                        state_d = StHalted;
                        pc_d    = pc_q;
                    end
                endcase
            end
            StLoad: begin
                wb_en   = 1'b1;
                wb_val  = ld_q;
                state_d = StFetch;
            end
            StHalted: state_d = StHalted;
            default:  state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StFetch;
            pc_q      <= '0;
            ir_q      <= '0;
            ld_q      <= '0;
            out_q     <= '0;
            outen_q   <= 1'b0;
            outflen_q <= 1'b0;
            halt_q    <= 1'b0;
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            ld_q      <= ld_d;
            out_q     <= out_d;
            outen_q   <= outen_d;
            outflen_q <= outflen_d;
            halt_q    <= halt_d;
            if (wb_en && (rd_idx != 5'd0)) regs_q[rd_idx] <= wb_val;
        end
    end

    // Memory survives reset; core stores are suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (oob_wen) begin
            mem[oob_wr_addr[AW-1:0]] <= oob_wr_data;
        end else if (mem_we && rst) begin
            mem[ls_addr[AW+1:2]] <= rs2_v;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{oob_wr_addr[31:AW]};

    assign pc      = pc_q;
    assign op      = ir_q[6:0];
    assign rd      = ir_q[11:7];
    assign imm1    = ir_q[31:25];
    assign x1      = regs_q[1];
    assign state   = state_q;
    assign out     = out_q;
    assign outen   = outen_q;
    assign outflen = outflen_q;
    assign halt    = halt_q;

endmodule

// File: tb/tb_comp.sv
// Directed self-checking bench for comp: small programs loaded out-of-band,
// output pulses collected per run and compared with hand-computed values.
module tb_comp;

    logic        clk = 1'b0;
    logic        rst;
    logic        oob_wen;
    logic [31:0] oob_wr_addr;
    logic [31:0] oob_wr_data;
    logic [31:0] pc;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [6:0]  imm1;
    logic [31:0] x1;
    logic [4:0]  state;
    logic [31:0] out;
    logic        outen;
    logic        outflen;
    logic        halt;

    comp dut (
        .clk         (clk),
        .rst         (rst),
        .oob_wen     (oob_wen),
        .oob_wr_addr (oob_wr_addr),
        .oob_wr_data (oob_wr_data),
        .pc          (pc),
        .op          (op),
        .rd          (rd),
        .imm1        (imm1),
        .x1          (x1),
        .state       (state),
        .out         (out),
        .outen       (outen),
        .outflen     (outflen),
        .halt        (halt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc;
    logic [31:0] prog [$];
    logic [31:0] ints [$];
    logic [31:0] flts [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] qint(input int i);
        return (i < ints.size()) ? ints[i] : 32'hxxxxxxxx;
    endfunction

    function automatic logic [31:0] ei(input int imm, input int rs1, input int f3, input int rdn,
                                       input logic [6:0] opc);
        logic [11:0] im;
        im = imm[11:0];
        return {im, rs1[4:0], f3[2:0], rdn[4:0], opc};
    endfunction

    function automatic logic [31:0] es(input int imm, input int rs2, input int rs1);
        logic [11:0] im;
        im = imm[11:0];
        return {im[11:5], rs2[4:0], rs1[4:0], 3'b010, im[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] eb(input int imm, input int rs2, input int rs1, input int f3);
        logic [12:0] im;
        im = imm[12:0];
        return {im[12], im[10:5], rs2[4:0], rs1[4:0], f3[2:0], im[4:1], im[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] eu(input int imm20, input int rdn, input logic [6:0] opc);
        logic [19:0] im;
        im = imm20[19:0];
        return {im, rdn[4:0], opc};
    endfunction

    function automatic logic [31:0] er(input int f7, input int rs2, input int rs1, input int f3,
                                       input int rdn);
        logic [6:0] f;
        f = f7[6:0];
        return {f, rs2[4:0], rs1[4:0], f3[2:0], rdn[4:0], 7'b0110011};
    endfunction

    function automatic logic [31:0] ej(input int imm, input int rdn);
        logic [20:0] im;
        im = imm[20:0];
        return {im[20], im[10:1], im[11], im[19:12], rdn[4:0], 7'b1101111};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_prog();
        for (int i = 0; i < prog.size(); i++) begin
            @(negedge clk);
            oob_wen     = 1'b1;
            oob_wr_addr = i;
            oob_wr_data = prog[i];
        end
        @(negedge clk);
        oob_wen = 1'b0;
    endtask

    // Release reset and collect output pulses until halt or the cycle budget runs out.
    task automatic run(input int max_cyc);
        ints.delete();
        flts.delete();
        cyc = 0;
        @(negedge clk);
        rst = 1'b1;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (outen) ints.push_back(out);
            if (outflen) flts.push_back(out);
            if (halt || cyc >= max_cyc) break;
        end
    endtask

    initial begin
        logic        stable;
        logic        pulse;
        rst         = 1'b0;
        oob_wen     = 1'b0;
        oob_wr_addr = '0;
        oob_wr_data = '0;
        repeat (2) @(negedge clk);

        check("rst_pc", pc, 32'd0);
        check("rst_state", {27'd0, state}, 32'd0);
        check("rst_ir", {18'd0, imm1, rd, op}, 32'd0);
        check("rst_out", {out[31:0]}, 32'd0);
        check("rst_flags", {29'd0, outen, outflen, halt}, 32'd0);

        // addi / sw out / halt
        prog = '{ei(5, 0, 0, 1, 7'h13), es(1000, 1, 0), es(1004, 0, 0)};
        load_prog();
        run(100);
        check("t1_halt", {31'd0, halt}, 32'd1);
        check("t1_cycles", cyc, 32'd6);
        check("t1_npulse", ints.size(), 32'd1);
        check("t1_out", qint(0), 32'd5);
        check("t1_x1", x1, 32'd5);
        check("t1_state", {27'd0, state}, 32'd3);
        check("t1_pc", pc, 32'd8);

        // lui + float output
        do_reset();
        prog = '{eu(20'h3fc00, 2, 7'h37), es(1008, 2, 0), es(1004, 0, 0)};
        load_prog();
        run(100);
        check("t2_nflt", flts.size(), 32'd1);
        check("t2_flt", (flts.size() > 0) ? flts[0] : 32'hxxxxxxxx, 32'h3fc00000);
        check("t2_nint", ints.size(), 32'd0);

        // counting loop with bne
        do_reset();
        prog = '{ei(0, 0, 0, 1, 7'h13), ei(4, 0, 0, 2, 7'h13), es(1000, 1, 0),
                 ei(1, 1, 0, 1, 7'h13), eb(-8, 2, 1, 1), es(1004, 0, 0)};
        load_prog();
        run(200);
        check("t3_npulse", ints.size(), 32'd4);
        for (int i = 0; i < 4; i++) check($sformatf("t3_out%0d", i), qint(i), i);
        check("t3_cycles", cyc, 32'd30);
        check("t3_x1", x1, 32'd4);

        // store/load round trip through data memory
        do_reset();
        prog = '{eu(20'h12345, 5, 7'h37), ei(12'h678, 5, 0, 5, 7'h13), es(12'h200, 5, 0),
                 ei(12'h200, 0, 2, 3, 7'h03), es(1000, 3, 0), es(1004, 0, 0)};
        load_prog();
        run(200);
        check("t4_out", qint(0), 32'h12345678);
        check("t4_cycles", cyc, 32'd13);
        check("t4_pc", pc, 32'd20);
        check("t4_op", {25'd0, op}, 32'h23);
        check("t4_rd", {27'd0, rd}, 32'd12);
        check("t4_imm1", {25'd0, imm1}, 32'd31);

        // srai / sub / sltu / jal
        do_reset();
        prog = '{ei(-16, 0, 0, 1, 7'h13), ei(12'h402, 1, 5, 2, 7'h13), es(1000, 2, 0),
                 er(7'h20, 1, 0, 0, 3), es(1000, 3, 0), er(0, 1, 0, 3, 4), ej(8, 5),
                 es(1004, 0, 0), es(1000, 4, 0), es(1000, 5, 0), es(1004, 0, 0)};
        load_prog();
        run(200);
        check("t5_npulse", ints.size(), 32'd4);
        check("t5_srai", qint(0), 32'hfffffffc);
        check("t5_sub", qint(1), 32'd16);
        check("t5_sltu", qint(2), 32'd1);
        check("t5_link", qint(3), 32'd28);
        check("t5_cycles", cyc, 32'd20);
        check("t5_x1", x1, 32'hfffffff0);

        // halted core stays frozen while the loader still writes memory
        stable = 1'b1;
        pulse  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            oob_wen     = (i == 5);
            oob_wr_addr = 32'd100;
            oob_wr_data = 32'hcafef00d;
            if (pc !== 32'd40 || state !== 5'd3 || halt !== 1'b1) stable = 1'b0;
            if (outen || outflen) pulse = 1'b1;
        end
        oob_wen = 1'b0;
        check("hold_stable", {31'd0, stable}, 32'd1);
        check("hold_nopulse", {31'd0, pulse}, 32'd0);
        check("hold_pc", pc, 32'd40);

        do_reset();
        prog = '{ei(400, 0, 2, 1, 7'h03), es(1000, 1, 0), es(1004, 0, 0)};
        load_prog();
        run(100);
        check("oob_halted_write", qint(0), 32'hcafef00d);
        check("oob_cycles", cyc, 32'd7);

        // reset asserted during EXEC of an output store
        do_reset();
        prog = '{es(1000, 0, 0), es(1004, 0, 0)};
        load_prog();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_exec_state", {27'd0, state}, 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_pc", pc, 32'd0);
        check("mid_rst_state", {27'd0, state}, 32'd0);
        pulse = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (outen || outflen || state != 5'd0) pulse = 1'b1;
        end
        check("mid_rst_nopulse", {31'd0, pulse}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
